// File: rtl/key_pkg.sv
// Shared constants and helpers for the key debounce block.
package key_pkg;

    // Pin level of a released (not pressed) key.
    localparam logic KEY_IDLE = 1'b1;

    // Defaults for the 24 MHz board clock.
    localparam int unsigned DB_CNT_DEF   = 32'd240000;    // 10 ms
    localparam int unsigned HOLD_CNT_DEF = 32'd12000000;  // 0.5 s
    localparam int unsigned REP_CNT_DEF  = 32'd2400000;   // 100 ms

    // Width of a counter that must hold values up to n-1, plus one spare bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key: two-flop synchroniser, debounce counter and press/release pulses.
// Auto-repeat (hold counter, rpt pulse) is built only when KEY_REPEAT_EN is defined.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DB_CNT   = DB_CNT_DEF,
    parameter int unsigned HOLD_CNT = HOLD_CNT_DEF,
    parameter int unsigned REP_CNT  = REP_CNT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic pressed_o,
    output logic press_o,
    output logic release_o,
    output logic rpt_o
);

    localparam int unsigned     DW      = cnt_w(DB_CNT);
    localparam logic [DW-1:0]   DB_LAST = DW'(DB_CNT - 1);

    if (DB_CNT < 2) begin : g_bad_db
        $error("key_debounce_ch: DB_CNT must be at least 2");
    end
    if (HOLD_CNT < 1 || REP_CNT < 1) begin : g_bad_rep
        $error("key_debounce_ch: HOLD_CNT and REP_CNT must be at least 1");
    end

    logic          s1_q, s2_q;
    logic          lvl;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          pressed_q, pressed_d;
    logic          press_q, release_q;
    logic          accept, rise, fall;
    logic          rep_fire;

    // Two-flop synchroniser; starts from the released level.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_q <= KEY_IDLE;
            s2_q <= KEY_IDLE;
        end else begin
            s1_q <= key_n_i;
            s2_q <= s1_q;
        end
    end

    assign lvl = ~s2_q;

    // Count consecutive cycles disagreeing with the accepted level; flip on the last one.
    always_comb begin
        cnt_d     = cnt_q;
        pressed_d = pressed_q;
        accept    = 1'b0;
        if (lvl == pressed_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
            pressed_d = lvl;
            cnt_d     = '0;
            accept    = 1'b1;
        end else begin
            cnt_d = cnt_q + DW'(1);
        end
    end

    assign rise = accept & lvl;
    assign fall = accept & ~lvl;

`ifdef KEY_REPEAT_EN
    localparam int unsigned   HMAX      = (HOLD_CNT > REP_CNT) ? HOLD_CNT : REP_CNT;
    localparam int unsigned   HW        = cnt_w(HMAX);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CNT - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REP_CNT - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          rep_q, rep_d;   // first repeat already issued, now pacing by REP_CNT

    // Hold/repeat timing; a release in progress wins over a due repeat pulse.
    always_comb begin
        hold_d   = hold_q;
        rep_d    = rep_q;
        rep_fire = 1'b0;
        if (!pressed_q || fall) begin
            hold_d = '0;
            rep_d  = 1'b0;
        end else if (hold_q == (rep_q ? REP_LAST : HOLD_LAST)) begin
            rep_fire = 1'b1;
            hold_d   = '0;
            rep_d    = 1'b1;
        end else begin
            hold_d = hold_q + HW'(1);
        end
    end

    // Hold/repeat state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hold_q <= '0;
            rep_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end

    logic rpt_q;

    // Registered repeat marker, coincident with the repeat press pulse.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) rpt_q <= 1'b0;
        else        rpt_q <= rep_fire;
    end

    assign rpt_o = rpt_q;
`else
    assign rep_fire = 1'b0;
    assign rpt_o    = 1'b0;
`endif

    // Debounce state and registered level/pulse outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            press_q   <= rise | rep_fire;
            release_q <= fall;
        end
    end

    assign pressed_o = pressed_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/key_debounce.sv
// KEYS independent active-low push-button debouncers with press/release pulses.
// Define KEY_REPEAT_EN to add auto-repeat (press + rpt pulses while held).
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned KEYS     = 3,
    parameter int unsigned DB_CNT   = DB_CNT_DEF,
    parameter int unsigned HOLD_CNT = HOLD_CNT_DEF,
    parameter int unsigned REP_CNT  = REP_CNT_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [KEYS-1:0] key_n_i,
    output logic [KEYS-1:0] pressed_o,
    output logic [KEYS-1:0] press_o,
    output logic [KEYS-1:0] release_o,
    output logic [KEYS-1:0] rpt_o
);

    for (genvar k = 0; k < KEYS; k++) begin : g_key
        key_debounce_ch #(
            .DB_CNT   (DB_CNT),
            .HOLD_CNT (HOLD_CNT),
            .REP_CNT  (REP_CNT)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .key_n_i   (key_n_i[k]),
            .pressed_o (pressed_o[k]),
            .press_o   (press_o[k]),
            .release_o (release_o[k]),
            .rpt_o     (rpt_o[k])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce (DB_CNT=4, HOLD_CNT=20, REP_CNT=8, KEYS=3).
// Honours KEY_REPEAT_EN in its reference model when the design is built with it.
module tb_key_debounce;

    localparam int KEYS = 3;
    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;
`ifdef KEY_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic [KEYS-1:0] key_n = '1;
    logic [KEYS-1:0] pressed, press, rel, rpt;

    key_debounce #(
        .KEYS(KEYS), .DB_CNT(DB), .HOLD_CNT(HOLD), .REP_CNT(REP)
    ) dut (
        .clk_i(clk), .rst_i(rst_n), .key_n_i(key_n),
        .pressed_o(pressed), .press_o(press), .release_o(rel), .rpt_o(rpt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: raw pin samples of the last DB+2 edges; a level change is
    // accepted when the DB synchronised samples (2 edges late) all disagree with it.
    logic [KEYS-1:0] hist [$];
    logic [KEYS-1:0] m_pressed, m_press, m_rel, m_rpt;
`ifdef KEY_REPEAT_EN
    int rise_cyc [KEYS];
`endif

    // pulse bookkeeping for table phases
    logic [KEYS-1:0] seen_press, seen_rel;
    int              n_press, n_rel;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DB + 2; i++) hist.push_back('1);
        m_pressed = '0; m_press = '0; m_rel = '0; m_rpt = '0;
    endtask

    task automatic model_step();
        bit acc;
        hist.push_back(key_n);
        if (hist.size() > DB + 2) void'(hist.pop_front());
        for (int k = 0; k < KEYS; k++) begin
            m_press[k] = 1'b0; m_rel[k] = 1'b0; m_rpt[k] = 1'b0;
            acc = 1'b1;
            for (int i = 0; i < DB; i++)
                if (hist[i][k] != m_pressed[k]) acc = 1'b0;
            if (acc) begin
                if (!m_pressed[k]) begin
                    m_press[k] = 1'b1;
`ifdef KEY_REPEAT_EN
                    rise_cyc[k] = cyc;
`endif
                end else begin
                    m_rel[k] = 1'b1;
                end
                m_pressed[k] = ~m_pressed[k];
            end
`ifdef KEY_REPEAT_EN
            else if (m_pressed[k]) begin
                int d;
                d = cyc - rise_cyc[k];
                if (d >= HOLD && (d - HOLD) % REP == 0) begin
                    m_press[k] = 1'b1;
                    m_rpt[k]   = 1'b1;
                end
            end
`endif
        end
    endtask

    task automatic chk(input string nm, input logic [KEYS-1:0] act, input logic [KEYS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %b want %b", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %0d want %0d", nm, cyc, act, exp);
        end
    endtask

    // One clock: DUT samples at posedge, model advances and outputs compared at negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        model_step();
        chk("pressed", pressed, m_pressed);
        chk("press",   press,   m_press);
        chk("release", rel,     m_rel);
        chk("rpt",     rpt,     m_rpt);
        seen_press |= press;
        seen_rel   |= rel;
        n_press    += $countones(press);
        n_rel      += $countones(rel);
    endtask

    typedef struct {
        logic [KEYS-1:0] kn;
        int              ncyc;
        logic [KEYS-1:0] exp_pressed;
        logic [KEYS-1:0] exp_press;    // keys with exactly one press pulse in the phase
        logic [KEYS-1:0] exp_rel;      // keys with exactly one release pulse in the phase
    } vec_t;

    vec_t tbl [$];

    initial begin
        int rem [KEYS];
        vec_t v;

        // ---- table of phases, all starting from released keys ----
        tbl.push_back('{3'b111, 8, 3'b000, 3'b000, 3'b000});
        for (int r = 0; r < 5; r++) begin        // key1 glitches: 3 low, 3 high
            tbl.push_back('{3'b101, 3, 3'b000, 3'b000, 3'b000});
            tbl.push_back('{3'b111, 3, 3'b000, 3'b000, 3'b000});
        end
        tbl.push_back('{3'b111, 6,  3'b000, 3'b000, 3'b000});
        tbl.push_back('{3'b010, 10, 3'b101, 3'b101, 3'b000}); // keys 0+2 together
        tbl.push_back('{3'b111, 10, 3'b000, 3'b000, 3'b101});
        tbl.push_back('{3'b011, 10, 3'b100, 3'b100, 3'b000}); // key2 press
        tbl.push_back('{3'b111, 2,  3'b100, 3'b000, 3'b000}); // short bounce
        tbl.push_back('{3'b011, 6,  3'b100, 3'b000, 3'b000});
        tbl.push_back('{3'b111, 10, 3'b000, 3'b000, 3'b100});

        // ---- reset state ----
        model_reset();
        seen_press = '0; seen_rel = '0; n_press = 0; n_rel = 0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_pressed", pressed, '0);
        chk("rst_press",   press,   '0);
        chk("rst_release", rel,     '0);
        chk("rst_rpt",     rpt,     '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();

        // ---- latency: key0 low after edge t -> press at edge t+6, release likewise ----
        key_n[0] = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            step();
            chk_int("lat_press0",   int'(press[0]), int'(i == 6));
            chk_int("lat_pressed0", int'(pressed[0]), int'(i >= 6));
            chk_int("lat_other",    int'(press[2:1]), 0);
        end
        key_n[0] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk_int("lat_rel0", int'(rel[0]), int'(i == 6));
        end

        // ---- table phases ----
        foreach (tbl[p]) begin
            v = tbl[p];
            key_n = v.kn;
            seen_press = '0; seen_rel = '0; n_press = 0; n_rel = 0;
            for (int i = 0; i < v.ncyc; i++) step();
            chk("tbl_pressed", pressed, v.exp_pressed);
            chk("tbl_press",   seen_press, v.exp_press);
            chk("tbl_release", seen_rel,   v.exp_rel);
            chk_int("tbl_npress", n_press, $countones(v.exp_press));
            chk_int("tbl_nrel",   n_rel,   $countones(v.exp_rel));
        end

        // ---- reset mid-press on key1 ----
        key_n[1] = 1'b0;
        repeat (15) step();
        chk_int("mid_pressed1", int'(pressed[1]), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pressed", pressed, '0);
        chk("mid_rst_press",   press,   '0);
        @(negedge clk);
        chk("mid_rst_hold", pressed, '0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 1; i <= 12; i++) begin
            step();
            chk_int("mid_press1", int'(press[1]), int'(i == 6));
        end
        key_n[1] = 1'b1;
        repeat (10) step();

        // ---- long hold on key0: repeats at 20,28,36,44,52 after rise (if enabled) ----
        key_n[0] = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            bit is_rep;
            if (i == 61) key_n[0] = 1'b1;    // release accepted at i=66 (d=60, repeat slot)
            step();
            is_rep = REP_EN && (i == 26 || i == 34 || i == 42 || i == 50 || i == 58);
            chk_int("hold_press0", int'(press[0]), int'(i == 6 || is_rep));
            chk_int("hold_rpt0",   int'(rpt[0]),   int'(is_rep));
            chk_int("hold_rel0",   int'(rel[0]),   int'(i == 66));
        end
        repeat (5) step();

        // ---- randomised runs: mix of glitches and long holds, occasional reset ----
        for (int k = 0; k < KEYS; k++) rem[k] = $urandom_range(1, 10);
        for (int n = 0; n < 4000; n++) begin
            for (int k = 0; k < KEYS; k++) begin
                rem[k]--;
                if (rem[k] <= 0) begin
                    key_n[k] = ~key_n[k];
                    rem[k] = ($urandom % 4 == 0) ? $urandom_range(1, 60) : $urandom_range(1, 6);
                end
            end
            step();
            if ($urandom % 700 == 0) begin
                rst_n = 1'b0;
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
